// File: rtl/alarm_bank.sv
// Multi-channel BCD alarm unit: per-channel stored times, minute-boundary match,
// ring/snooze state machines and a shared registered bell.
module alarm_bank #(
    parameter int NUM_ALARMS  = 4,
    parameter int SEL_W       = 2,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_MINS = 5,
    parameter int SNOOZE_MAX  = 3
) (
    input  logic                  CP,
    input  logic                  nCR,
    input  logic                  EN,
    input  logic                  sec_tick,
    input  logic                  min_tick,
    input  logic [3:0]            cur_hh,
    input  logic [3:0]            cur_hl,
    input  logic [3:0]            cur_mh,
    input  logic [3:0]            cur_ml,
    input  logic                  set_mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  inc_min,
    input  logic                  inc_hour,
    input  logic [NUM_ALARMS-1:0] alm_en,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [3:0]            rd_hh,
    output logic [3:0]            rd_hl,
    output logic [3:0]            rd_mh,
    output logic [3:0]            rd_ml,
    output logic [NUM_ALARMS-1:0] ring_vec,
    output logic [NUM_ALARMS-1:0] snz_vec,
    output logic                  bell
);

    localparam int RT_W  = $clog2(RING_SECS + 1);
    localparam int ST_W  = $clog2(SNOOZE_MINS + 1);
    localparam int CNT_W = (SNOOZE_MAX < 1) ? 1 : $clog2(SNOOZE_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } state_t;

    logic [3:0]       hh_q   [NUM_ALARMS];
    logic [3:0]       hl_q   [NUM_ALARMS];
    logic [3:0]       mh_q   [NUM_ALARMS];
    logic [3:0]       ml_q   [NUM_ALARMS];
    state_t           st_q   [NUM_ALARMS];
    logic [RT_W-1:0]  rtmr_q [NUM_ALARMS];
    logic [ST_W-1:0]  stmr_q [NUM_ALARMS];
    logic [CNT_W-1:0] cnt_q  [NUM_ALARMS];
    logic             bell_q;

    logic [3:0]       hh_d   [NUM_ALARMS];
    logic [3:0]       hl_d   [NUM_ALARMS];
    logic [3:0]       mh_d   [NUM_ALARMS];
    logic [3:0]       ml_d   [NUM_ALARMS];
    state_t           st_d   [NUM_ALARMS];
    logic [RT_W-1:0]  rtmr_d [NUM_ALARMS];
    logic [ST_W-1:0]  stmr_d [NUM_ALARMS];
    logic [CNT_W-1:0] cnt_d  [NUM_ALARMS];
    logic             bell_d;

    function automatic logic [7:0] bcd_min_inc(input logic [3:0] hi, input logic [3:0] lo);
        if (lo == 4'd9) begin
            bcd_min_inc = (hi == 4'd5) ? 8'h00 : {hi + 4'd1, 4'd0};
        end else begin
            bcd_min_inc = {hi, lo + 4'd1};
        end
    endfunction

    function automatic logic [7:0] bcd_hour_inc(input logic [3:0] hi, input logic [3:0] lo);
        if (hi == 4'd2 && lo == 4'd3) begin
            bcd_hour_inc = 8'h00;
        end else if (lo == 4'd9) begin
            bcd_hour_inc = {hi + 4'd1, 4'd0};
        end else begin
            bcd_hour_inc = {hi, lo + 4'd1};
        end
    endfunction

    always_comb begin
        bell_d = 1'b0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            hh_d[i]   = hh_q[i];
            hl_d[i]   = hl_q[i];
            mh_d[i]   = mh_q[i];
            ml_d[i]   = ml_q[i];
            st_d[i]   = st_q[i];
            rtmr_d[i] = rtmr_q[i];
            stmr_d[i] = stmr_q[i];
            cnt_d[i]  = cnt_q[i];
            if (EN) begin
                if (set_mode) begin
                    st_d[i]  = ST_IDLE;
                    cnt_d[i] = '0;
                    // Out-of-range sel never matches any channel index, so edits are dropped.
                    if (sel == SEL_W'(i)) begin
                        if (inc_min)  {mh_d[i], ml_d[i]} = bcd_min_inc(mh_q[i], ml_q[i]);
                        if (inc_hour) {hh_d[i], hl_d[i]} = bcd_hour_inc(hh_q[i], hl_q[i]);
                    end
                end else if (!alm_en[i]) begin
                    st_d[i] = ST_IDLE;
                end else begin
                    case (st_q[i])
                        ST_IDLE: begin
                            if (min_tick && {cur_hh, cur_hl, cur_mh, cur_ml} ==
                                            {hh_q[i], hl_q[i], mh_q[i], ml_q[i]}) begin
                                st_d[i]   = ST_RINGING;
                                rtmr_d[i] = '0;
                                cnt_d[i]  = '0;
                            end
                        end
                        ST_RINGING: begin
                            if (dismiss) begin
                                st_d[i]  = ST_IDLE;
                                cnt_d[i] = '0;
                            end else if (snooze && cnt_q[i] < CNT_W'(SNOOZE_MAX)) begin
                                st_d[i]   = ST_SNOOZE;
                                cnt_d[i]  = cnt_q[i] + 1'b1;
                                stmr_d[i] = '0;
                            end else if (sec_tick) begin
                                if (rtmr_q[i] == RT_W'(RING_SECS - 1)) st_d[i] = ST_IDLE;
                                else                                   rtmr_d[i] = rtmr_q[i] + 1'b1;
                            end
                        end
                        ST_SNOOZE: begin
                            if (dismiss) begin
                                st_d[i]  = ST_IDLE;
                                cnt_d[i] = '0;
                            end else if (min_tick) begin
                                if (stmr_q[i] == ST_W'(SNOOZE_MINS - 1)) begin
                                    st_d[i]   = ST_RINGING;
                                    rtmr_d[i] = '0;
                                end else begin
                                    stmr_d[i] = stmr_q[i] + 1'b1;
                                end
                            end
                        end
                        default: st_d[i] = ST_IDLE;
                    endcase
                end
            end
            // Bell follows next-state ringing so it rises together with ring_vec.
            if (EN && st_d[i] == ST_RINGING) bell_d = 1'b1;
        end
    end

    always_ff @(posedge CP or negedge nCR) begin
        if (!nCR) begin
            for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
                hh_q[i]   <= '0;
                hl_q[i]   <= '0;
                mh_q[i]   <= '0;
                ml_q[i]   <= '0;
                st_q[i]   <= ST_IDLE;
                rtmr_q[i] <= '0;
                stmr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            bell_q <= 1'b0;
        end else begin
            hh_q   <= hh_d;
            hl_q   <= hl_d;
            mh_q   <= mh_d;
            ml_q   <= ml_d;
            st_q   <= st_d;
            rtmr_q <= rtmr_d;
            stmr_q <= stmr_d;
            cnt_q  <= cnt_d;
            bell_q <= bell_d;
        end
    end

    always_comb begin
        rd_hh    = '0;
        rd_hl    = '0;
        rd_mh    = '0;
        rd_ml    = '0;
        ring_vec = '0;
        snz_vec  = '0;
        for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            ring_vec[i] = (st_q[i] == ST_RINGING);
            snz_vec[i]  = (st_q[i] == ST_SNOOZE);
            if (sel == SEL_W'(i)) begin
                rd_hh = hh_q[i];
                rd_hl = hl_q[i];
                rd_mh = mh_q[i];
                rd_ml = ml_q[i];
            end
        end
    end

    assign bell = bell_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: edit wrap, trigger/timeout, snooze limit,
// multi-channel, EN/set_mode/alm_en overrides and asynchronous reset.
module tb_alarm_bank;

    logic       CP = 1'b0;
    logic       nCR = 1'b0;
    logic       EN = 1'b0;
    logic       sec_tick = 1'b0;
    logic       min_tick = 1'b0;
    logic [3:0] cur_hh = '0, cur_hl = '0, cur_mh = '0, cur_ml = '0;
    logic       set_mode = 1'b0;
    logic [1:0] sel = '0;
    logic       inc_min = 1'b0;
    logic       inc_hour = 1'b0;
    logic [3:0] alm_en = '0;
    logic       snooze = 1'b0;
    logic       dismiss = 1'b0;
    logic [3:0] rd_hh, rd_hl, rd_mh, rd_ml;
    logic [3:0] ring_vec, snz_vec;
    logic       bell;

    int n_vec  = 0;
    int n_miss = 0;

    alarm_bank #(
        .NUM_ALARMS (4),
        .SEL_W      (2),
        .RING_SECS  (60),
        .SNOOZE_MINS(5),
        .SNOOZE_MAX (3)
    ) dut (
        .CP(CP), .nCR(nCR), .EN(EN), .sec_tick(sec_tick), .min_tick(min_tick),
        .cur_hh(cur_hh), .cur_hl(cur_hl), .cur_mh(cur_mh), .cur_ml(cur_ml),
        .set_mode(set_mode), .sel(sel), .inc_min(inc_min), .inc_hour(inc_hour),
        .alm_en(alm_en), .snooze(snooze), .dismiss(dismiss),
        .rd_hh(rd_hh), .rd_hl(rd_hl), .rd_mh(rd_mh), .rd_ml(rd_ml),
        .ring_vec(ring_vec), .snz_vec(snz_vec), .bell(bell)
    );

    always #5 CP = ~CP;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    task automatic edit(input logic m, input logic h, input int n);
        repeat (n) begin
            inc_min  = m;
            inc_hour = h;
            tick();
            inc_min  = 1'b0;
            inc_hour = 1'b0;
        end
    endtask

    task automatic set_cur(input logic [15:0] t);
        {cur_hh, cur_hl, cur_mh, cur_ml} = t;
    endtask

    task automatic mtick();
        min_tick = 1'b1;
        tick();
        min_tick = 1'b0;
    endtask

    task automatic stick(input int n);
        repeat (n) begin
            sec_tick = 1'b1;
            tick();
            sec_tick = 1'b0;
        end
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
    endtask

    task automatic pulse_dismiss();
        dismiss = 1'b1;
        tick();
        dismiss = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_ring", ring_vec, 4'b0000);
        check("rst_snz", snz_vec, 4'b0000);
        check("rst_bell", bell, 1'b0);
        check("rst_rd", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0000);
        tick();
        nCR = 1'b1;
        tick();

        // Edit wrap on channel 2
        EN = 1'b1; set_mode = 1'b1; sel = 2'd2;
        edit(1, 0, 10); check("min10", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0010);
        edit(1, 0, 49); check("min59", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0059);
        edit(1, 0, 1);  check("min_wrap", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0000);
        edit(0, 1, 9);  check("hr09", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0900);
        edit(0, 1, 14); check("hr23", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h2300);
        edit(0, 1, 1);  check("hr_wrap", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0000);
        sel = 2'd1; #1;
        check("ch1_untouched", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0000);

        // Channel 3: both increments at once, then to 12:00
        sel = 2'd3;
        edit(1, 1, 1);  check("both_inc", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0101);
        edit(0, 1, 11);
        edit(1, 0, 59); check("ch3_1200", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h1200);
        sel = 2'd1; edit(0, 1, 12);
        sel = 2'd2; edit(0, 1, 12); check("ch2_1200", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h1200);
        sel = 2'd0; edit(0, 1, 7); edit(1, 0, 30);
        check("ch0_0730", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0730);
        EN = 1'b0; edit(1, 1, 1); EN = 1'b1;
        check("edit_en_low", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0730);
        set_mode = 1'b0;

        // Trigger and ring timeout
        alm_en = 4'b0001;
        set_cur(16'h0731); mtick();
        check("no_match", ring_vec, 4'b0000);
        set_cur(16'h0730); tick();
        check("no_min_tick", ring_vec, 4'b0000);
        mtick();
        check("trig_ring", ring_vec, 4'b0001);
        check("trig_bell", bell, 1'b1);
        set_cur(16'h0800);
        stick(59); check("ring_59s", ring_vec, 4'b0001);
        stick(1);
        check("timeout_ring", ring_vec, 4'b0000);
        check("timeout_bell", bell, 1'b0);

        // Snooze cycle, limit of three
        set_cur(16'h0730); mtick(); set_cur(16'h0800);
        check("snz_start_ring", ring_vec, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            pulse_snooze();
            check("snz_vec", snz_vec, 4'b0001);
            check("snz_ring", ring_vec, 4'b0000);
            check("snz_bell", bell, 1'b0);
            repeat (4) mtick();
            check("snz_4min", snz_vec, 4'b0001);
            mtick();
            check("snz_rering", ring_vec, 4'b0001);
            check("snz_rebell", bell, 1'b1);
        end
        pulse_snooze();
        check("snz_limit_ring", ring_vec, 4'b0001);
        check("snz_limit_snz", snz_vec, 4'b0000);
        pulse_dismiss();
        check("dis_ring", ring_vec, 4'b0000);
        check("dis_snz", snz_vec, 4'b0000);
        check("dis_bell", bell, 1'b0);

        // Multi-channel; ch2 at 12:00 is disarmed
        alm_en = 4'b1010;
        set_cur(16'h1200); mtick(); set_cur(16'h0800);
        check("multi_ring", ring_vec, 4'b1010);
        check("multi_bell", bell, 1'b1);
        pulse_dismiss();
        check("multi_dis", ring_vec, 4'b0000);
        set_cur(16'h1200);
        min_tick = 1'b1; dismiss = 1'b1;
        tick();
        min_tick = 1'b0; dismiss = 1'b0;
        set_cur(16'h0800);
        check("trig_with_dis", ring_vec, 4'b1010);
        pulse_dismiss();
        check("multi_dis2", ring_vec, 4'b0000);

        // EN freeze, set_mode and alm_en overrides
        alm_en = 4'b0001;
        set_cur(16'h0730); mtick(); set_cur(16'h0800);
        check("ovr_ring", ring_vec, 4'b0001);
        EN = 1'b0; tick();
        check("en_low_bell", bell, 1'b0);
        dismiss = 1'b1;
        repeat (9) tick();
        dismiss = 1'b0;
        check("en_low_ring", ring_vec, 4'b0001);
        check("en_low_bell10", bell, 1'b0);
        EN = 1'b1; tick();
        check("en_back_bell", bell, 1'b1);
        check("en_back_ring", ring_vec, 4'b0001);
        set_mode = 1'b1; tick(); set_mode = 1'b0;
        check("setmode_ring", ring_vec, 4'b0000);
        check("setmode_bell", bell, 1'b0);
        set_cur(16'h0730); mtick(); set_cur(16'h0800);
        pulse_snooze();
        check("pre_dis_snz", snz_vec, 4'b0001);
        alm_en = 4'b0000; tick();
        check("disarm_snz", snz_vec, 4'b0000);
        check("disarm_ring", ring_vec, 4'b0000);

        // Asynchronous reset while ringing and editing
        alm_en = 4'b0001;
        set_cur(16'h0730); mtick(); set_cur(16'h0800);
        check("pre_rst_ring", ring_vec, 4'b0001);
        set_mode = 1'b1; sel = 2'd0; inc_min = 1'b1;
        #2 nCR = 1'b0;
        #1;
        check("arst_ring", ring_vec, 4'b0000);
        check("arst_bell", bell, 1'b0);
        check("arst_rd0", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0000);
        sel = 2'd3; #1;
        check("arst_rd3", {rd_hh, rd_hl, rd_mh, rd_ml}, 16'h0000);
        inc_min = 1'b0; set_mode = 1'b0;
        tick();
        nCR = 1'b1;
        tick();
        check("post_rst_ring", ring_vec, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Parametrised multi-channel alarm unit for the digital clock, successor to the single-alarm bell set/ring logic.
- Holds NUM_ALARMS independent BCD alarm times, editable one channel at a time in set mode.
- Compares each channel against the running BCD time at every minute boundary and runs a per-channel ring/snooze state machine.
- Drives one shared bell output.

Parameters:
NUM_ALARMS, 4, number of alarm channels (1..16)
SEL_W, 2, channel-select width, must equal clog2(NUM_ALARMS) (min 1)
RING_SECS, 60, sec_tick pulses a channel rings before auto-timeout (1..255)
SNOOZE_MINS, 5, min_tick pulses spent in snooze before re-ringing (1..59)
SNOOZE_MAX, 3, snoozes allowed per alarm event (0..7)

Ports:
CP  in  1  system clock, all state on rising edge
nCR  in  1  reset, asynchronous, active-low
EN  in  1  global enable; low freezes all state
sec_tick  in  1  one-CP pulse per second
min_tick  in  1  one-CP pulse per minute, asserted in the cycle the cur_* inputs show the new minute
cur_hh, cur_hl, cur_mh, cur_ml  in  4 each  current time, BCD, 24 h
set_mode  in  1  alarm edit mode
sel  in  SEL_W  channel being edited/read back
inc_min, inc_hour  in  1  one-cycle edit pulses for channel sel
alm_en  in  NUM_ALARMS  per-channel arm bits
snooze, dismiss  in  1  one-cycle user pulses, act on all active channels
rd_hh, rd_hl, rd_mh, rd_ml  out  4 each  stored time of channel sel, combinational
ring_vec  out  NUM_ALARMS  channel in RINGING
snz_vec  out  NUM_ALARMS  channel in SNOOZE
bell  out  1  registered; EN & |ring_vec

Behaviour:
- Reset (nCR low, any time, including mid-ring): all alarm times 00:00, all channels IDLE, timers and snooze counts 0, ring_vec = snz_vec = 0, bell = 0.
- EN low: no register changes, bell forced 0 next edge. Pulses arriving while EN low are lost.
- Edit (EN & set_mode):
  - inc_min: channel sel minute +1, BCD 00..59, 59 -> 00, no carry into hour.
  - inc_hour: hour +1, BCD 00..23, 23 -> 00.
  - Both high: both apply.
  - sel >= NUM_ALARMS: ignored.
  - Stored digits are always valid BCD.
- set_mode high: all channels forced IDLE on the next edge, triggers suppressed, snooze counts cleared.
- Per-channel FSM, encoded as localparams:
  - IDLE -> RINGING when EN, !set_mode, alm_en[i], min_tick, and cur time == stored time (all four digits). Ring timer and snooze count cleared. ring_vec[i] rises the edge after the min_tick cycle; bell one edge later at most, being registered from the same condition (bell high in the same cycle as ring_vec).
  - RINGING:
    - sec_tick increments the ring timer; reaching RING_SECS -> IDLE (timeout).
    - dismiss -> IDLE, count cleared.
    - snooze with count < SNOOZE_MAX -> SNOOZE, count +1, snooze timer cleared.
    - snooze with count == SNOOZE_MAX: ignored, keeps ringing.
  - SNOOZE:
    - min_tick increments the snooze timer; reaching SNOOZE_MINS -> RINGING, ring timer cleared.
    - dismiss -> IDLE, count cleared.
  - Match/min_tick in RINGING or SNOOZE does not retrigger.
  - alm_en[i] low in any state -> IDLE next edge.
- Priority per channel: nCR > set_mode > !alm_en > dismiss > snooze > timer expiry > trigger.
- dismiss and snooze act only on channels non-IDLE at that edge; a channel triggering in the same cycle as dismiss enters RINGING.
- Several channels may ring simultaneously. bell is their OR; one snooze/dismiss acts on all of them.
- Timer widths are sized from the parameters; no wrap is reachable.

Test Plan:
- Edit wrap: set_mode, sel=2, 60× inc_min from 00:00 -> rd_mh/rd_ml = 0/0 and hour unchanged; 24× inc_hour -> rd 00:00; sel=1 reads 00:00 throughout.
- Trigger: ch0 = 07:30, alm_en=0001, drive cur 07:30 with min_tick -> ring_vec=0001, bell=1 next edge; RING_SECS sec_ticks -> ring_vec=0, bell=0.
- Snooze cycle: ringing ch0, snooze -> snz_vec=0001, bell=0; 5 min_ticks -> ring_vec=0001. Repeat snooze 3×; 4th snooze ignored, still ringing; dismiss -> all 0.
- Multi-channel: ch1 and ch3 both 12:00, both armed, match -> ring_vec=1010; single dismiss -> 0000. ch2 at 12:00 but disarmed never rings.
- Overrides: ringing ch0, assert EN=0 for 10 cycles -> state frozen, bell=0; EN=1 -> bell=1. Then set_mode=1 -> IDLE; drop alm_en[0] mid-snooze -> IDLE.
- Reset mid-operation: nCR low asynchronously while ringing and mid-edit -> all outputs 0 and rd 00:00 immediately, without waiting for a CP edge.
